layer0_input_packer: RTL

LAYER0_INPUT_PACKER -- requirements
Module: layer0_input_packer

---
 rtl/layer0_input_packer.sv | 110 +++++++++++
 1 files changed

// File: rtl/layer0_input_packer.sv
// layer0_input_packer: collects NUM_FEAT serial FEAT_W-bit features into one packed
// layer-0 input vector. Feature 0 lands in the LSBs. The next vector can be
// collected while the previous one is held on m_data.
// Optional framing checks on s_last are built in when LAYER0_PACK_FRAME_CHK_EN is defined;
// otherwise s_last is ignored and err is tied low.
module layer0_input_packer #(
  parameter int unsigned FEAT_W   = 2,
  parameter int unsigned NUM_FEAT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  output logic [FEAT_W*NUM_FEAT-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       err
);

  localparam int unsigned IdxW = $clog2(NUM_FEAT);
  localparam int unsigned VecW = FEAT_W * NUM_FEAT;

  logic [IdxW-1:0] idx_q, idx_d;
  logic [VecW-1:0] shadow_q, shadow_d;
  logic [VecW-1:0] m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            last_slot;
  logic            accept;
  logic            early_err;
  logic            final_err;

  // The final beat can only be taken when the output register is free or draining.
  always_comb begin
    last_slot = (idx_q == IdxW'(NUM_FEAT - 1));
    s_ready   = !last_slot || !m_valid_q || m_ready;
    accept    = s_valid && s_ready;
  end

`ifdef LAYER0_PACK_FRAME_CHK_EN
  logic err_q;

  assign early_err = accept && s_last && !last_slot;
  assign final_err = accept && !s_last && last_slot;
  assign err       = err_q;

  // One-cycle framing-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= early_err || final_err;
    end
  end
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign early_err     = 1'b0;
  assign final_err     = 1'b0;
  assign err           = 1'b0;
`endif

  // Next-state: fill shadow, publish on the final beat, drain on m_ready.
  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (early_err || final_err) begin
        // Drop the partial vector; stale shadow bits are overwritten before reuse.
        idx_d = '0;
      end else if (last_slot) begin
        m_data_d                      = shadow_q;
        m_data_d[VecW-1 -: FEAT_W]    = s_data;
        m_valid_d                     = 1'b1;
        idx_d                         = '0;
      end else begin
        shadow_d[int'(idx_q)*FEAT_W +: FEAT_W] = s_data;
        idx_d                                  = idx_q + IdxW'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule
